fix_length_p2b: RTL and testbench
=================================

# fix_length_p2b

Converts a fixed-length Avalon-ST packet stream of multi-byte symbols back into a flat byte stream. It is the inverse of the fixed-length bytes-to-packets packer and sits at the egress side of the same datapath. It validates packet framing (SOP/EOP against the fixed symbol count) and serializes each accepted symbol most-significant byte first, with full ready/valid backpressure on both sides.

## Interface
Parameters:
- SYMBOL_PER_PACKET, 4, symbols per packet (>=1)
- BYTES_PER_SYMBOL, 4, bytes per input symbol (>=1)
- BITS_PER_BYTES, 8, width of one output byte

Ports:
- clock_clk  in  1  single clock; all logic on rising edge
- reset_reset  in  1  reset, synchronous, active-high
- asi_in0_data  in  BYTES_PER_SYMBOL*BITS_PER_BYTES  input symbol
- asi_in0_valid  in  1  symbol valid
- asi_in0_ready  out  1  symbol accepted when valid&&ready
- asi_in0_startofpacket  in  1  first symbol of packet
- asi_in0_endofpacket  in  1  last symbol of packet
- aso_out0_data  out  BITS_PER_BYTES  output byte
- aso_out0_valid  out  1  byte valid
- aso_out0_ready  in  1  byte consumed when valid&&ready
- coe_err_framing  out  1  one-cycle pulse per framing violation
- coe_pkt_done  out  1  one-cycle pulse when last byte of a packet is consumed

## Operation
- State: IDLE (no packet open) / IN_PKT (packet open); independent serializer holding register, byte index bidx (0..BYTES_PER_SYMBOL-1), busy flag.
- Symbol counter scnt, width $clog2(SYMBOL_PER_PACKET)+1, counts accepted symbols in the open packet.
- Accepted symbol framing:
  - IDLE, SOP=1: forward, scnt<=1 (or close immediately if SYMBOL_PER_PACKET=1), go IN_PKT.
  - IDLE, SOP=0: drop (not serialized), err pulse, stay IDLE.
  - IN_PKT, SOP=1: err pulse; treat as first symbol of a new packet, scnt<=1; forwarded.
  - Symbol at index SYMBOL_PER_PACKET-1: forward, go IDLE, scnt<=0; if EOP=0, err pulse.
  - EOP=1 at any earlier index: forward, err pulse, go IDLE, scnt<=0 (packet truncated).
  - At most one err pulse per accepted symbol.
- Serialization: byte k of symbol = bits [(BYTES_PER_SYMBOL-k)*BITS_PER_BYTES-1 -: BITS_PER_BYTES]; k=0 emitted first.
- Forwarded symbols tagged as packet-final if they closed the packet; coe_pkt_done pulses the cycle its last byte handshakes. Dropped symbols produce no bytes and no pkt_done.

## Timing
- Reset (synchronous): state IDLE, scnt=0, bidx=0, busy=0; aso_out0_valid=0, aso_out0_data=0, coe_err_framing=0, coe_pkt_done=0. asi_in0_ready=0 while reset_reset=1.
- asi_in0_ready = !reset_reset && (!busy || (bidx==BYTES_PER_SYMBOL-1 && aso_out0_ready)); combinational path from aso_out0_ready is intentional.
- Latency: symbol accepted at edge N -> byte 0 valid after edge N (cycle N+1). Dropped symbols are accepted (ready may be 1) and discarded.
- Sustained throughput with aso_out0_ready=1: one byte per cycle, no bubble between back-to-back symbols.
- aso_out0_valid/data held stable until handshake; never withdrawn without handshake except by reset.
- coe_err_framing registered, asserted the cycle after the offending accept.
- Reset mid-packet: in-flight symbol and partial bytes discarded, no pulses.

## Structure
- Shared package fix_length_pkg: state encoding (IDLE, IN_PKT), width helper localparams (symbol-count and byte-index widths) used by both the packer and this block.
- One sub-module: fix_length_symbol_serializer (holding register, bidx, busy, ready/valid out); framing FSM and counters live in the top.

## Test plan
Defaults SYMBOL_PER_PACKET=4, BYTES_PER_SYMBOL=4, BITS_PER_BYTES=8.
- Clean packet, aso_out0_ready=1: symbols 0x00010203..0x0C0D0E0F with SOP on first, EOP on fourth -> bytes 0x00..0x0F in order, 16 consecutive cycles, one pkt_done on byte 0x0F, no err.
- Backpressure: aso_out0_ready toggles 1/0 -> each byte held stable while stalled; asi_in0_ready low while busy; order intact.
- Orphan symbol: IDLE, symbol 0xDEADBEEF with SOP=0 -> accepted, no output bytes, one err pulse; following valid packet serialized normally.
- Early EOP: EOP on second symbol -> 8 bytes out, err pulse, pkt_done on 8th byte; next SOP opens new packet.
- Missing EOP / SOP mid-packet: fourth symbol EOP=0 -> err, packet closes; SOP on third symbol -> err, scnt restarts, packet ends 3 symbols later.
- Reset asserted mid-symbol (after 2 bytes) -> next cycle valid=0, state IDLE; no further bytes from that symbol.

Source files
------------

// File: rtl/fix_length_pkg.sv
// Shared definitions for the fixed-length packer/unpacker pair: framing state
// encoding and counter-width helpers.
package fix_length_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } fl_state_e;

  // Symbol counter holds 0..SYMBOL_PER_PACKET, hence one spare bit.
  function automatic int scnt_width(input int symbols_per_packet);
    return $clog2(symbols_per_packet) + 1;
  endfunction

  function automatic int bidx_width(input int bytes_per_symbol);
    return (bytes_per_symbol > 1) ? $clog2(bytes_per_symbol) : 1;
  endfunction

endpackage

// File: rtl/fix_length_symbol_serializer.sv
// Holds one symbol and emits it MS byte first, one byte per output handshake.
// Takes a new symbol on the cycle its final byte leaves, so no bubbles.
module fix_length_symbol_serializer
  import fix_length_pkg::*;
#(
  parameter int BYTES_PER_SYMBOL = 4,
  parameter int BITS_PER_BYTES   = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   sym_load_i,
  input  logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] sym_dat_i,
  input  logic                                   sym_last_i,
  output logic                                   sym_rdy_o,
  input  logic                                   byte_rdy_i,
  output logic                                   byte_vld_o,
  output logic [BITS_PER_BYTES-1:0]              byte_dat_o,
  output logic                                   pkt_done_o
);

  localparam int SYM_W  = BYTES_PER_SYMBOL * BITS_PER_BYTES;
  localparam int BIDX_W = bidx_width(BYTES_PER_SYMBOL);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES_PER_SYMBOL - 1);

  logic [SYM_W-1:0]  hold_q, hold_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;
  logic              on_last_byte;
  logic              byte_fire;

  assign on_last_byte = (bidx_q == BIDX_LAST);
  assign byte_fire    = busy_q && byte_rdy_i;
  assign sym_rdy_o    = !rst_i && (!busy_q || (on_last_byte && byte_rdy_i));
  assign byte_vld_o   = busy_q;
  assign pkt_done_o   = !rst_i && byte_fire && on_last_byte && last_q;

  always_comb begin
    byte_dat_o = '0;
    for (int k = 0; k < BYTES_PER_SYMBOL; k++) begin
      if (bidx_q == BIDX_W'(k)) begin
        byte_dat_o = hold_q[(BYTES_PER_SYMBOL-k)*BITS_PER_BYTES-1 -: BITS_PER_BYTES];
      end
    end
  end

  always_comb begin
    hold_d = hold_q;
    bidx_d = bidx_q;
    busy_d = busy_q;
    last_d = last_q;
    // A load always coincides with the final byte leaving (or an empty register).
    if (sym_load_i) begin
      hold_d = sym_dat_i;
      last_d = sym_last_i;
      bidx_d = '0;
      busy_d = 1'b1;
    end else if (byte_fire) begin
      if (on_last_byte) begin
        busy_d = 1'b0;
        bidx_d = '0;
      end else begin
        bidx_d = bidx_q + BIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
      bidx_q <= '0;
      busy_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      bidx_q <= bidx_d;
      busy_q <= busy_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fix_length_p2b.sv
// Fixed-length packet-of-symbols to byte-stream converter with framing checks.
// Byte 0 one cycle after accept; input ready follows output ready combinationally.
module fix_length_p2b
  import fix_length_pkg::*;
#(
  parameter int SYMBOL_PER_PACKET = 4,
  parameter int BYTES_PER_SYMBOL  = 4,
  parameter int BITS_PER_BYTES    = 8
) (
  input  logic                                   clock_clk,
  input  logic                                   reset_reset,
  input  logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] asi_in0_data,
  input  logic                                   asi_in0_valid,
  output logic                                   asi_in0_ready,
  input  logic                                   asi_in0_startofpacket,
  input  logic                                   asi_in0_endofpacket,
  output logic [BITS_PER_BYTES-1:0]              aso_out0_data,
  output logic                                   aso_out0_valid,
  input  logic                                   aso_out0_ready,
  output logic                                   coe_err_framing,
  output logic                                   coe_pkt_done
);

  localparam int SCNT_W = scnt_width(SYMBOL_PER_PACKET);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SYMBOL_PER_PACKET - 1);

  fl_state_e         state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic              err_q, err_d;
  logic              accept;
  logic              fwd;
  logic              close;
  logic [SCNT_W-1:0] pos;
  logic              at_last;

  assign accept  = asi_in0_valid && asi_in0_ready;
  // An SOP always restarts numbering, even in the middle of an open packet.
  assign pos     = asi_in0_startofpacket ? '0 : scnt_q;
  assign at_last = (pos == SCNT_LAST);

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    err_d   = 1'b0;
    fwd     = 1'b0;
    close   = 1'b0;
    if (accept) begin
      if (!asi_in0_startofpacket && state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        fwd   = 1'b1;
        close = at_last || asi_in0_endofpacket;
        err_d = (asi_in0_startofpacket && state_q == IN_PKT) ||
                (at_last ? !asi_in0_endofpacket : asi_in0_endofpacket);
        if (close) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else begin
          state_d = IN_PKT;
          scnt_d  = pos + SCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
    end
  end

  assign coe_err_framing = err_q;

  fix_length_symbol_serializer #(
    .BYTES_PER_SYMBOL(BYTES_PER_SYMBOL),
    .BITS_PER_BYTES  (BITS_PER_BYTES)
  ) u_ser (
    .clk_i     (clock_clk),
    .rst_i     (reset_reset),
    .sym_load_i(accept && fwd),
    .sym_dat_i (asi_in0_data),
    .sym_last_i(close),
    .sym_rdy_o (asi_in0_ready),
    .byte_rdy_i(aso_out0_ready),
    .byte_vld_o(aso_out0_valid),
    .byte_dat_o(aso_out0_data),
    .pkt_done_o(coe_pkt_done)
  );

endmodule

// File: tb/tb_fix_length_p2b.sv
// Bench for fix_length_p2b: symbol table runs, randomized traffic and reset
// corner cases, all scored against a byte-queue reference model.
module tb_fix_length_p2b;

  localparam int SPP = 4;
  localparam int BPS = 4;
  localparam int BB  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_dat;
  logic        in_vld, in_rdy, in_sop, in_eop;
  logic [7:0]  out_dat;
  logic        out_vld, out_rdy;
  logic        err, done;

  always #5 clk = ~clk;

  fix_length_p2b #(
    .SYMBOL_PER_PACKET(SPP),
    .BYTES_PER_SYMBOL (BPS),
    .BITS_PER_BYTES   (BB)
  ) dut (
    .clock_clk            (clk),
    .reset_reset          (rst),
    .asi_in0_data         (in_dat),
    .asi_in0_valid        (in_vld),
    .asi_in0_ready        (in_rdy),
    .asi_in0_startofpacket(in_sop),
    .asi_in0_endofpacket  (in_eop),
    .aso_out0_data        (out_dat),
    .aso_out0_valid       (out_vld),
    .aso_out0_ready       (out_rdy),
    .coe_err_framing      (err),
    .coe_pkt_done         (done)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int out_mode = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: expected byte stream plus framing rules on packet position.
  typedef struct { logic [7:0] d; bit last; int idx; } ebyte_t;
  typedef struct { int cyc; logic [7:0] d; } olog_t;

  ebyte_t expq[$];
  olog_t  out_log[$];
  bit     m_open = 0;
  int     m_cnt = 0;
  bit     exp_err = 0;
  int     acc_cnt = 0;
  int     prev_acc = -1;
  bit     prev_rst = 0;
  bit     err_flags[1024];
  int     byte_cnt[1024];
  bit     done_flags[1024];

  function automatic void model_accept(input logic [31:0] d, input bit sop, input bit eop, input int idx);
    bit e = 0;
    bit cl = 0;
    int p;
    ebyte_t b;
    if (!sop && !m_open) begin
      exp_err = 1;
      return;
    end
    if (sop) begin
      if (m_open) e = 1;
      m_cnt = 0;
    end
    p = m_cnt;
    m_cnt++;
    if (p == SPP - 1) begin
      cl = 1;
      if (!eop) e = 1;
    end else if (eop) begin
      cl = 1;
      e = 1;
    end
    m_open = !cl;
    if (cl) m_cnt = 0;
    for (int k = 0; k < BPS; k++) begin
      b.d    = 8'(d >> ((BPS - 1 - k) * BB));
      b.last = cl && (k == BPS - 1);
      b.idx  = idx;
      expq.push_back(b);
    end
    exp_err = e;
  endfunction

  ebyte_t mon_e;
  bit     mon_fire;

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_in_reset", 32'(in_rdy), 32'd0);
      if (prev_rst) begin
        check("valid_in_reset", 32'(out_vld), 32'd0);
        check("data_in_reset", 32'(out_dat), 32'd0);
        check("err_in_reset", 32'(err), 32'd0);
        check("done_in_reset", 32'(done), 32'd0);
      end
      expq.delete();
      m_open = 0;
      m_cnt = 0;
      exp_err = 0;
      prev_acc = -1;
      prev_rst = 1;
    end else begin
      prev_rst = 0;
      check("in_ready", 32'(in_rdy), 32'(expq.size() == 0 || (expq.size() == 1 && out_rdy)));
      check("out_valid", 32'(out_vld), 32'(expq.size() != 0));
      check("err_pulse", 32'(err), 32'(exp_err));
      if (err && prev_acc >= 0) err_flags[prev_acc] = 1;
      mon_fire = out_vld && out_rdy;
      if (out_vld && expq.size() != 0) begin
        mon_e = expq[0];
        check("out_data", 32'(out_dat), 32'(mon_e.d));
        check("pkt_done", 32'(done), 32'(mon_fire && mon_e.last));
        if (mon_fire) begin
          byte_cnt[mon_e.idx]++;
          if (done) done_flags[mon_e.idx] = 1;
          out_log.push_back('{cyc: cycle, d: out_dat});
          void'(expq.pop_front());
        end
      end else begin
        check("pkt_done_idle", 32'(done), 32'd0);
      end
      exp_err = 0;
      prev_acc = -1;
      if (in_vld && in_rdy) begin
        model_accept(in_dat, in_sop, in_eop, acc_cnt);
        prev_acc = acc_cnt;
        acc_cnt++;
      end
    end
  end

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = !out_rdy;
        default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send(input logic [31:0] d, input bit sop, input bit eop);
    int n = 0;
    bit got = 0;
    in_dat = d;
    in_sop = sop;
    in_eop = eop;
    in_vld = 1'b1;
    while (!got) begin
      @(negedge clk);
      got = in_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!got && n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) check("drain_timeout", 32'(expq.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] d;
    bit          sop;
    bit          eop;
    bit          x_err;
    int          x_bytes;
    bit          x_done;
  } vec_t;

  vec_t tbl[$];

  task automatic run_table(input int mode);
    int base;
    int lb;
    out_mode = mode;
    base = acc_cnt;
    lb = out_log.size();
    foreach (tbl[i]) send(tbl[i].d, tbl[i].sop, tbl[i].eop);
    drain();
    foreach (tbl[i]) begin
      check($sformatf("tbl%0d_err", i), 32'(err_flags[base + i]), 32'(tbl[i].x_err));
      check($sformatf("tbl%0d_bytes", i), 32'(byte_cnt[base + i]), 32'(tbl[i].x_bytes));
      check($sformatf("tbl%0d_done", i), 32'(done_flags[base + i]), 32'(tbl[i].x_done));
    end
    if (mode == 0) begin
      // First packet: bytes 0x00..0x0F on 16 consecutive cycles.
      for (int i = 0; i < 16; i++) begin
        check($sformatf("clean_byte%0d", i), 32'(out_log[lb + i].d), 32'(i));
        check($sformatf("clean_cyc%0d", i), 32'(out_log[lb + i].cyc - out_log[lb].cyc), 32'(i));
      end
    end
  endtask

  initial begin
    int base;
    int lb;
    int dpos;
    int r;
    bit sop;
    bit eop;
    for (int i = 0; i < 1024; i++) begin
      err_flags[i] = 0;
      byte_cnt[i] = 0;
      done_flags[i] = 0;
    end
    rst = 1'b1;
    in_vld = 1'b0;
    in_dat = '0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    tbl.push_back('{32'h00010203, 1, 0, 0, 4, 0});
    tbl.push_back('{32'h04050607, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h08090A0B, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h0C0D0E0F, 0, 1, 0, 4, 1});
    tbl.push_back('{32'hDEADBEEF, 0, 0, 1, 0, 0});
    tbl.push_back('{32'h11121314, 1, 0, 0, 4, 0});
    tbl.push_back('{32'h21222324, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h31323334, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h41424344, 0, 1, 0, 4, 1});
    tbl.push_back('{32'h51525354, 1, 0, 0, 4, 0});
    tbl.push_back('{32'h61626364, 0, 1, 1, 4, 1});
    tbl.push_back('{32'h71727374, 1, 0, 0, 4, 0});
    tbl.push_back('{32'h81828384, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h91929394, 0, 0, 0, 4, 0});
    tbl.push_back('{32'hA1A2A3A4, 0, 0, 1, 4, 1});
    tbl.push_back('{32'hB1B2B3B4, 1, 0, 0, 4, 0});
    tbl.push_back('{32'hC1C2C3C4, 0, 0, 0, 4, 0});
    tbl.push_back('{32'hD1D2D3D4, 1, 0, 1, 4, 0});
    tbl.push_back('{32'hE1E2E3E4, 0, 0, 0, 4, 0});
    tbl.push_back('{32'hF1F2F3F4, 0, 0, 0, 4, 0});
    tbl.push_back('{32'h0A0B0C0D, 0, 1, 0, 4, 1});
    tbl.push_back('{32'h12345678, 1, 1, 1, 4, 1});
    tbl.push_back('{32'hCAFEF00D, 0, 1, 1, 0, 0});

    run_table(0);
    run_table(1);
    run_table(2);

    // Randomized framing and backpressure.
    out_mode = 2;
    dpos = 0;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      sop = (dpos == 0) ? (r < 90) : (r < 6);
      r = $urandom_range(0, 99);
      eop = (dpos == SPP - 1) ? (r < 90) : (r < 6);
      send($urandom, sop, eop);
      dpos = eop ? 0 : (dpos + 1) % SPP;
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    drain();

    // Reset after two bytes of a symbol have left.
    out_mode = 0;
    drain();
    lb = out_log.size();
    send(32'hA5B6C7D8, 1, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("valid_after_reset", 32'(out_vld), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bytes_before_reset", 32'(out_log.size() - lb), 32'd2);
    check("reset_byte0", 32'(out_log[lb].d), 32'hA5);
    check("reset_byte1", 32'(out_log[lb + 1].d), 32'hB6);
    // Block must be back in IDLE: a non-SOP symbol is an orphan.
    base = acc_cnt;
    send(32'h12121212, 0, 0);
    drain();
    check("post_reset_orphan_err", 32'(err_flags[base]), 32'd1);
    check("post_reset_orphan_bytes", 32'(byte_cnt[base]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
